manchester_rx_1553: RTL and testbench

Receive-side MIL-STD-1553 word decoder: recovers command/status and data words from the oversampled Manchester II serial stream produced by the transmit encoder. It detects the 3-bit-time sync, samples 16 data bits plus odd parity, flags Manchester and parity errors, and presents each word with a one-cycle valid strobe to the protocol logic in the bus controller/RT path.

---
 rtl/pkg_1553.sv | 20 ++
 rtl/manchester_rx_1553_if.sv | 21 ++
 rtl/sync_detect_1553.sv | 40 ++++
 rtl/manchester_rx_1553.sv | 105 ++++++++++
 tb/tb_manchester_rx_1553.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pkg_1553.sv
// Shared MIL-STD-1553 decoder definitions: word geometry, FSM states, sync types.
package pkg_1553;

  localparam int WORD_BITS = 16;
  localparam int SYNC_BITS = 3;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} rx_state_t;

  // Sync-type encoding shared with the transmit encoder
  typedef enum logic [1:0] {
    SYNC_NONE = 2'b00,
    SYNC_CSW  = 2'b01,
    SYNC_DW   = 2'b10
  } sync_t;

  function automatic logic odd_parity_fail(input logic [WORD_BITS:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/manchester_rx_1553_if.sv
// Receive-side bus bundle between the 1553 word decoder and the protocol logic.
interface manchester_rx_1553_if;
  logic                            rx_data;
  logic [pkg_1553::WORD_BITS-1:0]  rx_dword;
  logic                            rx_dval;
  logic                            rx_csw;
  logic                            rx_dw;
  logic                            rx_perr;
  logic                            rx_merr;
  logic                            rx_busy;

  modport master (
    input  rx_data,
    output rx_dword, rx_dval, rx_csw, rx_dw, rx_perr, rx_merr, rx_busy
  );

  modport slave (
    output rx_data,
    input  rx_dword, rx_dval, rx_csw, rx_dw, rx_perr, rx_merr, rx_busy
  );
endinterface

// File: rtl/sync_detect_1553.sv
// Synchronizes rx_data, keeps a 3-bit-time sample window and matches both sync patterns.
module sync_detect_1553
  import pkg_1553::*;
#(
  parameter int SPB = 8
) (
  input  logic dec_clk,
  input  logic rst_n,
  input  logic rx_data,
  output logic rx_s,
  output logic csw_hit,
  output logic dw_hit
);

  localparam int WLEN = SYNC_BITS * SPB;
  localparam int H    = WLEN / 2;

  logic            s1, s2;
  logic [WLEN-1:0] w;
  logic            unused_dc;

  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      w  <= '0;
    end else begin
      s1 <= rx_data;
      s2 <= s1;
      w  <= {w[WLEN-2:0], s2};
    end
  end

  // The two samples around the mid-sync edge are ignored to allow +/-1 sample skew
  assign unused_dc = ^w[H:H-1];
  assign csw_hit   = (&w[WLEN-1:H+1]) & ~(|w[H-2:0]);
  assign dw_hit    = ~(|w[WLEN-1:H+1]) & (&w[H-2:0]);
  assign rx_s      = w[0];

endmodule

// File: rtl/manchester_rx_1553.sv
// MIL-STD-1553 Manchester II word decoder: sync hunt, bit-cell sampling, parity check.
module manchester_rx_1553
  import pkg_1553::*;
#(
  parameter int SPB = 8
) (
  input  logic                  dec_clk,
  input  logic                  rst_n,
  manchester_rx_1553_if.master  rx
);

  localparam int             CW   = $clog2(SPB);
  localparam logic [CW-1:0]  Q1   = CW'(SPB / 4);
  localparam logic [CW-1:0]  Q3   = CW'(3 * SPB / 4);
  localparam logic [CW-1:0]  LAST = CW'(SPB - 1);
  localparam logic [4:0]     PBIT = 5'(WORD_BITS);

  logic                 rx_s, csw_hit, dw_hit;
  rx_state_t            state;
  sync_t                styp;
  logic [CW-1:0]        scnt;
  logic [4:0]           bcnt;
  logic                 h1, h2;
  logic [WORD_BITS-1:0] shreg;
  logic [WORD_BITS-1:0] dword_q;
  logic                 dval_q, csw_q, dw_q, perr_q, merr_q, busy_q;

  sync_detect_1553 #(.SPB(SPB)) u_sync (
    .dec_clk (dec_clk),
    .rst_n   (rst_n),
    .rx_data (rx.rx_data),
    .rx_s    (rx_s),
    .csw_hit (csw_hit),
    .dw_hit  (dw_hit)
  );

  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      styp    <= SYNC_NONE;
      scnt    <= '0;
      bcnt    <= '0;
      h1      <= 1'b0;
      h2      <= 1'b0;
      shreg   <= '0;
      dword_q <= '0;
      dval_q  <= 1'b0;
      csw_q   <= 1'b0;
      dw_q    <= 1'b0;
      perr_q  <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dval_q <= 1'b0;
      merr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (csw_hit || dw_hit) begin
            styp   <= csw_hit ? SYNC_CSW : SYNC_DW;
            scnt   <= '0;
            bcnt   <= '0;
            busy_q <= 1'b1;
            state  <= DATA;
          end
        end
        DATA: begin
          scnt <= scnt + CW'(1);
          if (scnt == Q1) h1 <= rx_s;
          if (scnt == Q3) h2 <= rx_s;
          if (scnt == LAST) begin
            scnt <= '0;
            if (h1 == h2) begin
              merr_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else if (bcnt == PBIT) begin
              // Strobe on the parity resolve; CHECK only spaces out the next hunt
              dword_q <= shreg;
              csw_q   <= (styp == SYNC_CSW);
              dw_q    <= (styp == SYNC_DW);
              perr_q  <= odd_parity_fail({shreg, h1});
              dval_q  <= 1'b1;
              busy_q  <= 1'b0;
              state   <= CHECK;
            end else begin
              shreg <= {shreg[WORD_BITS-2:0], h1};
              bcnt  <= bcnt + 5'd1;
            end
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.rx_dword = dword_q;
  assign rx.rx_dval  = dval_q;
  assign rx.rx_csw   = csw_q;
  assign rx.rx_dw    = dw_q;
  assign rx.rx_perr  = perr_q;
  assign rx.rx_merr  = merr_q;
  assign rx.rx_busy  = busy_q;

endmodule

// File: tb/tb_manchester_rx_1553.sv
// Directed bench for manchester_rx_1553: builds Manchester streams and checks decoded words.
module tb_manchester_rx_1553;

  localparam int SPB = 8;
  localparam int H   = 3 * SPB / 2;

  logic dec_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   failures = 0;
  int   last_edge = 0;
  int   merr_cnt = 0;
  int   consec   = 0;
  logic prev_dval = 1'b0;

  typedef struct {
    logic [15:0] w;
    logic        csw;
    logic        dw;
    logic        perr;
    int          c;
  } rec_t;

  rec_t q[$];
  rec_t mon_r;

  manchester_rx_1553_if bus ();

  manchester_rx_1553 #(.SPB(SPB)) dut (
    .dec_clk (dec_clk),
    .rst_n   (rst_n),
    .rx      (bus)
  );

  always #5 dec_clk = ~dec_clk;
  always @(posedge dec_clk) cyc <= cyc + 1;

  always @(negedge dec_clk) begin
    if (bus.rx_dval) begin
      mon_r.w    = bus.rx_dword;
      mon_r.csw  = bus.rx_csw;
      mon_r.dw   = bus.rx_dw;
      mon_r.perr = bus.rx_perr;
      mon_r.c    = cyc;
      q.push_back(mon_r);
    end
    if (bus.rx_merr) merr_cnt++;
    if (bus.rx_dval && prev_dval) consec++;
    prev_dval = bus.rx_dval;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One sample per cycle; last_edge is the cyc value once this sample is clocked in
  task automatic drive(input logic v);
    @(posedge dec_clk);
    #1;
    bus.rx_data = v;
    last_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.rx_dword, bus.rx_dval, bus.rx_csw, bus.rx_dw,
                bus.rx_perr, bus.rx_merr, bus.rx_busy});
  endfunction

  task automatic send(input logic is_csw, input logic [15:0] d, input logic flip_par,
                      input int bad_bit, input int shift, input int rst_bit);
    logic [16:0] b;
    logic        v;
    b = {d, (~(^d)) ^ flip_par};
    for (int i = 0; i < H + shift; i++) drive(is_csw);
    for (int i = 0; i < H - shift; i++) drive(~is_csw);
    for (int k = 0; k < 17; k++) begin
      if (k == rst_bit) begin
        @(posedge dec_clk);
        #1;
        check("rst_busy_before", 32'(bus.rx_busy), 32'd1);
        rst_n = 1'b0;
        bus.rx_data = 1'b0;
        #1;
        check("rst_outputs_zero", out_vec(), 32'd0);
        repeat (3) @(posedge dec_clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      for (int j = 0; j < SPB; j++) begin
        v = (j < SPB / 2 || k == bad_bit) ? b[16-k] : ~b[16-k];
        drive(v);
      end
    end
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w, input logic csw,
                             input logic dw, input logic perr, output int c);
    rec_t r;
    c = -1;
    if (q.size() > 0) begin
      r = q.pop_front();
      c = r.c;
      check({tag, "_word"}, 32'(r.w), 32'(w));
      check({tag, "_csw"},  32'(r.csw), 32'(csw));
      check({tag, "_dw"},   32'(r.dw), 32'(dw));
      check({tag, "_perr"}, 32'(r.perr), 32'(perr));
    end
  endtask

  initial begin
    int le, c1, c2, m0;
    bus.rx_data = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge dec_clk);
    #1;
    check("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Command word, csw sync, latency from final parity sample
    send(1'b1, 16'h5555, 1'b0, -1, 0, -1);
    le = last_edge;
    idle(10);
    check("t1_count", 32'(q.size()), 32'd1);
    expect_word("t1", 16'h5555, 1'b1, 1'b0, 1'b0, c1);
    check("t1_latency", 32'(c1 - le), 32'd3);
    check("t1_busy_idle", 32'(bus.rx_busy), 32'd0);
    q.delete();

    send(1'b0, 16'hABCD, 1'b0, -1, 0, -1);
    idle(10);
    check("t2_count", 32'(q.size()), 32'd1);
    expect_word("t2", 16'hABCD, 1'b0, 1'b1, 1'b0, c1);
    q.delete();

    // Back-to-back data words
    send(1'b0, 16'hFFFF, 1'b0, -1, 0, -1);
    send(1'b0, 16'h1234, 1'b0, -1, 0, -1);
    idle(10);
    check("t3_count", 32'(q.size()), 32'd2);
    expect_word("t3a", 16'hFFFF, 1'b0, 1'b1, 1'b0, c1);
    expect_word("t3b", 16'h1234, 1'b0, 1'b1, 1'b0, c2);
    check("t3_spacing", 32'(c2 - c1), 32'(20 * SPB));
    q.delete();

    send(1'b1, 16'h5678, 1'b1, -1, 0, -1);
    idle(10);
    check("t4_count", 32'(q.size()), 32'd1);
    expect_word("t4", 16'h5678, 1'b1, 1'b0, 1'b1, c1);
    q.delete();

    // Manchester violation in bit 5, then a clean word
    m0 = merr_cnt;
    send(1'b1, 16'hAAAA, 1'b0, 5, 0, -1);
    idle(10);
    check("t5_merr", 32'(merr_cnt - m0), 32'd1);
    check("t5_no_dval", 32'(q.size()), 32'd0);
    check("t5_busy_idle", 32'(bus.rx_busy), 32'd0);
    q.delete();
    send(1'b0, 16'h0001, 1'b0, -1, 0, -1);
    idle(10);
    check("t5b_count", 32'(q.size()), 32'd1);
    expect_word("t5b", 16'h0001, 1'b0, 1'b1, 1'b0, c1);
    q.delete();

    // Reset at bit 8, then normal decode
    send(1'b1, 16'hC3A5, 1'b0, -1, 0, 8);
    idle(20);
    check("t6_no_dval", 32'(q.size()), 32'd0);
    q.delete();
    send(1'b1, 16'h3C5A, 1'b0, -1, 0, -1);
    idle(10);
    check("t6b_count", 32'(q.size()), 32'd1);
    expect_word("t6b", 16'h3C5A, 1'b1, 1'b0, 1'b0, c1);
    q.delete();

    // Mid-sync edge shifted late and early by one sample
    send(1'b1, 16'h0F0F, 1'b0, -1, 1, -1);
    idle(10);
    check("t7a_count", 32'(q.size()), 32'd1);
    expect_word("t7a", 16'h0F0F, 1'b1, 1'b0, 1'b0, c1);
    q.delete();
    send(1'b1, 16'hF0F1, 1'b0, -1, -1, -1);
    idle(10);
    check("t7b_count", 32'(q.size()), 32'd1);
    expect_word("t7b", 16'hF0F1, 1'b1, 1'b0, 1'b0, c1);
    q.delete();

    check("dval_never_consecutive", 32'(consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
